// File: rtl/left_signal_head_monitor.sv
// Left-turn signal head: decodes light_color into lamp drives, checks the colour sequence,
// and latches a fault with flashing-red fail-safe. Watchdog built only with LEFT_SIGNAL_WATCHDOG_EN.
module left_signal_head_monitor #(
  parameter int BLINK_HALF = 4,
  parameter int MIN_YELLOW = 2,
  parameter int MAX_DWELL  = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] light_color,
  input  logic       fault_clr,
  output logic       lamp_red,
  output logic       lamp_yellow,
  output logic       lamp_green,
  output logic       fault,
  output logic [1:0] fault_code
);

  localparam logic [1:0] C_GREEN  = 2'b00;
  localparam logic [1:0] C_YELLOW = 2'b01;
  localparam logic [1:0] C_RED    = 2'b10;
  localparam logic [1:0] C_FLASH  = 2'b11;
  localparam int         BW       = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  if (BLINK_HALF < 1 || MAX_DWELL < 1) begin : g_bad_param
    $error("BLINK_HALF and MAX_DWELL must be >= 1");
  end

  typedef enum logic [1:0] {ST_INIT, ST_RUN, ST_FAULT} state_t;

  state_t          state_q, state_d;
  logic [1:0]      prev_q;
  logic [15:0]     dwell_q, dwell_d;
  logic [BW-1:0]   blink_cnt_q, blink_cnt_d;
  logic            blink_phase_q, blink_phase_d;
  logic            red_q, red_d, yel_q, yel_d, grn_q, grn_d;
  logic            fault_q, fault_d;
  logic [1:0]      code_q, code_d;
  logic            change, blink_restart;

  function automatic logic [15:0] dwell_sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // any->red is always allowed; the rest is the controller's normal cycle
  function automatic logic legal_step(input logic [1:0] from, input logic [1:0] to);
    return (to == C_RED) ||
           (from == C_GREEN && to == C_YELLOW) ||
           (from == C_RED   && to == C_GREEN)  ||
           (from == C_RED   && to == C_FLASH)  ||
           (from == C_FLASH && to == C_YELLOW);
  endfunction

  always_comb begin
    change        = (light_color != prev_q);
    dwell_d       = change ? 16'd1 : dwell_sat_inc(dwell_q);
    state_d       = state_q;
    code_d        = code_q;
    blink_restart = 1'b0;
    case (state_q)
      ST_INIT: if (light_color == C_RED) state_d = ST_RUN;
      ST_RUN: begin
        if (change && !legal_step(prev_q, light_color)) begin
          state_d = ST_FAULT;
          code_d  = 2'd1;
        end else if (change && prev_q == C_YELLOW && dwell_q < 16'(MIN_YELLOW)) begin
          state_d = ST_FAULT;
          code_d  = 2'd2;
`ifdef LEFT_SIGNAL_WATCHDOG_EN
        end else if (!change && prev_q != C_RED && dwell_d >= 16'(MAX_DWELL)) begin
          state_d = ST_FAULT;
          code_d  = 2'd3;
`endif
        end else if (change && light_color == C_FLASH) begin
          blink_restart = 1'b1;
        end
      end
      ST_FAULT: if (fault_clr && light_color == C_RED) begin
        state_d = ST_RUN;
        code_d  = 2'd0;
      end
      default: state_d = ST_INIT;
    endcase
    if (state_q != ST_FAULT && state_d == ST_FAULT) blink_restart = 1'b1;

    // restart makes the first blink phase "on"
    if (blink_restart) begin
      blink_cnt_d   = '0;
      blink_phase_d = 1'b1;
    end else if (blink_cnt_q == BW'(BLINK_HALF - 1)) begin
      blink_cnt_d   = '0;
      blink_phase_d = ~blink_phase_q;
    end else begin
      blink_cnt_d   = blink_cnt_q + BW'(1);
      blink_phase_d = blink_phase_q;
    end

    red_d   = 1'b0;
    yel_d   = 1'b0;
    grn_d   = 1'b0;
    fault_d = (state_d == ST_FAULT);
    case (state_d)
      ST_RUN: case (light_color)
        C_GREEN:  grn_d = 1'b1;
        C_YELLOW: yel_d = 1'b1;
        C_RED:    red_d = 1'b1;
        default:  yel_d = blink_phase_d;
      endcase
      ST_FAULT: red_d = blink_phase_d;
      default:  red_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_INIT;
      prev_q        <= C_RED;
      dwell_q       <= 16'd1;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b1;
      red_q         <= 1'b1;
      yel_q         <= 1'b0;
      grn_q         <= 1'b0;
      fault_q       <= 1'b0;
      code_q        <= 2'd0;
    end else begin
      state_q       <= state_d;
      prev_q        <= light_color;
      dwell_q       <= dwell_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      red_q         <= red_d;
      yel_q         <= yel_d;
      grn_q         <= grn_d;
      fault_q       <= fault_d;
      code_q        <= code_d;
    end
  end

  assign lamp_red    = red_q;
  assign lamp_yellow = yel_q;
  assign lamp_green  = grn_q;
  assign fault       = fault_q;
  assign fault_code  = code_q;

endmodule

// File: tb/tb_left_signal_head_monitor.sv
// Directed bench for left_signal_head_monitor: expected outputs are queued when a step is driven
// and popped one edge later when the registered outputs are sampled.
module tb_left_signal_head_monitor;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] light_color;
  logic       fault_clr;
  logic       lamp_red, lamp_yellow, lamp_green, fault;
  logic [1:0] fault_code;

  int errors = 0;
  int checks = 0;

`ifdef LEFT_SIGNAL_WATCHDOG_EN
  localparam int FY_N = 12;
`else
  localparam int FY_N = 20;
`endif

  typedef struct packed {
    logic       red;
    logic       yel;
    logic       grn;
    logic       flt;
    logic [1:0] code;
  } exp_t;

  exp_t sb[$];

  left_signal_head_monitor #(.BLINK_HALF(4), .MIN_YELLOW(3), .MAX_DWELL(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .light_color(light_color),
    .fault_clr  (fault_clr),
    .lamp_red   (lamp_red),
    .lamp_yellow(lamp_yellow),
    .lamp_green (lamp_green),
    .fault      (fault),
    .fault_code (fault_code)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  function automatic exp_t mk(input logic r, input logic y, input logic g,
                              input logic f, input logic [1:0] c);
    exp_t e;
    e.red = r; e.yel = y; e.grn = g; e.flt = f; e.code = c;
    return e;
  endfunction

  function automatic logic on_phase(input int k);
    return ((k / 4) % 2) == 0;
  endfunction

  task automatic cmp(input string tag, input string name, input logic [1:0] act, input logic [1:0] exp);
    checks++;
    assert (act === exp)
    else begin
      errors++;
      $error("FAIL %s.%s observed=%0d expected=%0d", tag, name, act, exp);
    end
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    checks++;
    assert (sb.size() != 0)
    else begin
      errors++;
      $error("FAIL %s.scoreboard observed=empty expected=entry", tag);
      return;
    end
    e = sb.pop_front();
    cmp(tag, "lamp_red",    {1'b0, lamp_red},    {1'b0, e.red});
    cmp(tag, "lamp_yellow", {1'b0, lamp_yellow}, {1'b0, e.yel});
    cmp(tag, "lamp_green",  {1'b0, lamp_green},  {1'b0, e.grn});
    cmp(tag, "fault",       {1'b0, fault},       {1'b0, e.flt});
    cmp(tag, "fault_code",  fault_code,          e.code);
  endtask

  task automatic step(input logic [1:0] lc, input logic clr, input exp_t e, input string tag);
    @(negedge clk);
    light_color = lc;
    fault_clr   = clr;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check_out(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    sb.push_back(mk(1, 0, 0, 0, 0));
    #2;
    check_out("reset");
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    light_color = 2'b10;
    fault_clr   = 1'b0;
    do_reset();

    // normal sequence
    for (int i = 0; i < 5; i++) step(2'b10, 0, mk(1, 0, 0, 0, 0), "norm_red1");
    for (int i = 0; i < 6; i++) step(2'b00, 0, mk(0, 0, 1, 0, 0), "norm_green");
    for (int i = 0; i < 3; i++) step(2'b01, 0, mk(0, 1, 0, 0, 0), "norm_yellow");
    for (int i = 0; i < 5; i++) step(2'b10, 0, mk(1, 0, 0, 0, 0), "norm_red2");

    // short yellow then blinking fault display and clear rules
    for (int i = 0; i < 2; i++) step(2'b00, 0, mk(0, 0, 1, 0, 0), "sy_green");
    for (int i = 0; i < 2; i++) step(2'b01, 0, mk(0, 1, 0, 0, 0), "sy_yellow");
    step(2'b10, 0, mk(1, 0, 0, 1, 2), "sy_fault");
    for (int k = 1; k < 8; k++) step(2'b10, 0, mk(on_phase(k), 0, 0, 1, 2), "sy_blink");
    step(2'b00, 1, mk(on_phase(8), 0, 0, 1, 2), "clr_not_red");
    step(2'b10, 1, mk(1, 0, 0, 0, 0), "clr_red");
    step(2'b10, 1, mk(1, 0, 0, 0, 0), "clr_outside_fault");
    step(2'b10, 0, mk(1, 0, 0, 0, 0), "after_clr");

    // yellow held exactly the minimum is legal
    for (int i = 0; i < 2; i++) step(2'b00, 0, mk(0, 0, 1, 0, 0), "my_green");
    for (int i = 0; i < 3; i++) step(2'b01, 0, mk(0, 1, 0, 0, 0), "my_yellow");
    for (int i = 0; i < 2; i++) step(2'b10, 0, mk(1, 0, 0, 0, 0), "my_red");

    // illegal transition green -> flashing yellow; later violations ignored
    for (int i = 0; i < 3; i++) step(2'b00, 0, mk(0, 0, 1, 0, 0), "il_green");
    step(2'b11, 0, mk(1, 0, 0, 1, 1), "il_fault");
    for (int k = 1; k < 9; k++) step(2'b11, 0, mk(on_phase(k), 0, 0, 1, 1), "il_blink");
    step(2'b00, 0, mk(on_phase(9), 0, 0, 1, 1), "il_hold_code");
    step(2'b10, 1, mk(1, 0, 0, 0, 0), "il_clear");

    // flashing yellow from red, then legal exit to yellow
    step(2'b10, 0, mk(1, 0, 0, 0, 0), "fy_red");
    for (int i = 0; i < FY_N; i++) step(2'b11, 0, mk(0, on_phase(i), 0, 0, 0), "fy_blink");
    for (int i = 0; i < 3; i++) step(2'b01, 0, mk(0, 1, 0, 0, 0), "fy_yellow");
    for (int i = 0; i < 2; i++) step(2'b10, 0, mk(1, 0, 0, 0, 0), "fy_red2");

    // short yellow plus illegal on one edge: illegal wins
    step(2'b00, 0, mk(0, 0, 1, 0, 0), "both_green");
    step(2'b01, 0, mk(0, 1, 0, 0, 0), "both_yellow");
    step(2'b00, 0, mk(1, 0, 0, 1, 1), "both_fault");
    step(2'b00, 0, mk(1, 0, 0, 1, 1), "both_hold");

    // asynchronous reset in the middle of a fault
    do_reset();
    step(2'b10, 0, mk(1, 0, 0, 0, 0), "post_reset_red");

`ifdef LEFT_SIGNAL_WATCHDOG_EN
    for (int i = 0; i < 100; i++) step(2'b10, 0, mk(1, 0, 0, 0, 0), "wd_red_hold");
    for (int i = 0; i < 15; i++) step(2'b00, 0, mk(0, 0, 1, 0, 0), "wd_green");
    step(2'b00, 0, mk(1, 0, 0, 1, 3), "wd_fault");
    do_reset();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
